// File: rtl/cam_match_iterator_if.sv
// Handshake bundle between the CAM match decoder, the iterator and the result consumer.
// The slave side is the iterator; the master side is whoever drives vectors and consumes beats.
interface cam_match_iterator_if #(
  parameter int unsigned CAM_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 4
);
  logic                  match_valid;
  logic [CAM_DEPTH-1:0]  match_vector;
  logic                  match_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_hit;
  logic                  out_last;
  logic [CNT_WIDTH-1:0]  match_count;
  logic                  multi_match;

  modport master (
    output match_valid, match_vector, out_ready,
    input  match_ready, out_valid, out_addr, out_hit, out_last, match_count, multi_match
  );

  modport slave (
    input  match_valid, match_vector, out_ready,
    output match_ready, out_valid, out_addr, out_hit, out_last, match_count, multi_match
  );
endinterface

// File: rtl/cam_match_iterator.sv
// Walks a captured multi-hot CAM match vector and emits one encoded row address per beat,
// lowest row first; an empty vector yields a single miss beat.
module cam_match_iterator #(
  parameter int unsigned CAM_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  cam_match_iterator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEmit, StMiss} state_e;

  state_e                state_q;
  logic [CAM_DEPTH-1:0]  pending_q;
  logic [CNT_WIDTH-1:0]  match_count_q;
  logic                  multi_match_q;

  logic [CAM_DEPTH-1:0]  pending_rest;
  logic                  pending_single;
  logic [ADDR_WIDTH-1:0] pending_low;
  logic [CNT_WIDTH-1:0]  vector_count;

  function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [CAM_DEPTH-1:0] v);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = int'(CAM_DEPTH) - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [CAM_DEPTH-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < int'(CAM_DEPTH); i++) begin
      c = c + CNT_WIDTH'(v[i]);
    end
    return c;
  endfunction

  // x & (x-1) drops the lowest set bit; a zero result means exactly one bit was pending.
  assign pending_rest   = pending_q & (pending_q - CAM_DEPTH'(1));
  assign pending_single = (pending_q != '0) && (pending_rest == '0);
  assign pending_low    = lowest_index(pending_q);
  assign vector_count   = popcount(bus.match_vector);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      match_count_q <= '0;
      multi_match_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.match_valid) begin
            pending_q     <= bus.match_vector;
            match_count_q <= vector_count;
            multi_match_q <= (vector_count > CNT_WIDTH'(1));
            state_q       <= (bus.match_vector != '0) ? StEmit : StMiss;
          end
        end
        StEmit: begin
          if (bus.out_ready) begin
            pending_q <= pending_rest;
            if (pending_single) state_q <= StIdle;
          end
        end
        StMiss: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Beat outputs depend only on registered state so the consumer sees no input-to-output path.
  always_comb begin
    bus.match_ready = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_addr    = '0;
    bus.out_hit     = 1'b0;
    bus.out_last    = 1'b0;
    unique case (state_q)
      StIdle: bus.match_ready = 1'b1;
      StEmit: begin
        bus.out_valid = 1'b1;
        bus.out_hit   = 1'b1;
        bus.out_addr  = pending_low;
        bus.out_last  = pending_single;
      end
      StMiss: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.match_count = match_count_q;
  assign bus.multi_match = multi_match_q;

endmodule
